// File: rtl/vc_arbiter_pkg.sv
// Shared constants for the virtual-channel arbiter: link-state one-hot codes,
// arbiter FSM encoding and the default channel count.
package vc_arb_pkg;

    localparam logic [3:0] ST_RESET  = 4'b0001;
    localparam logic [3:0] ST_INIT   = 4'b0010;
    localparam logic [3:0] ST_IDLE   = 4'b0100;
    localparam logic [3:0] ST_ACTIVE = 4'b1000;

    localparam int DEF_NUM_CH = 5;

    typedef enum logic [1:0] {
        FSM_WAIT  = 2'd0,
        FSM_GRANT = 2'd1,
        FSM_GAP   = 2'd2
    } fsm_e;

endpackage

// File: rtl/vc_arbiter_rr_next_sel.sv
// Round-robin next-channel search: first non-empty channel after i_ptr,
// wrapping NUM_CH-1 back to 0. Purely combinational.
module rr_next_sel #(
    parameter int NUM_CH = 5,
    parameter int IDX_W  = 3
) (
    input  logic [IDX_W-1:0]  i_ptr,
    input  logic [NUM_CH-1:0] i_empty,
    output logic [IDX_W-1:0]  o_sel,
    output logic              o_valid
);

    logic [IDX_W:0] w_cand;

    // Walk offsets from farthest to nearest so the nearest non-empty channel wins.
    always_comb begin
        o_sel   = '0;
        o_valid = 1'b0;
        w_cand  = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            w_cand  = {1'b0, i_ptr} + (IDX_W+1)'(k);
            w_cand  = (w_cand >= (IDX_W+1)'(NUM_CH)) ? (w_cand - (IDX_W+1)'(NUM_CH)) : w_cand;
            o_sel   = (!i_empty[w_cand[IDX_W-1:0]]) ? w_cand[IDX_W-1:0] : o_sel;
            o_valid = o_valid | !i_empty[w_cand[IDX_W-1:0]];
        end
    end

endmodule

// File: rtl/vc_arbiter.sv
// Virtual-channel FIFO arbiter: WAIT/GRANT/GAP FSM with registered grant outputs.
// Optional burst retention is enabled by defining VC_ARB_BURST_EN.
module vc_arbiter
    import vc_arb_pkg::*;
#(
    parameter int NUM_CH    = DEF_NUM_CH,
    parameter int IDX_W     = 3,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic [3:0]        state,
    input  logic [NUM_CH-1:0] empty,
    input  logic              pause,
    output logic [IDX_W-1:0]  idx,
    output logic              req,
    output logic [NUM_CH-1:0] pop
);

    if ((1 << IDX_W) < NUM_CH) begin : g_bad_idx_w
        $error("IDX_W too narrow for NUM_CH");
    end
    if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_burst
        $error("MAX_BURST out of range 1..15");
    end

    fsm_e               r_fsm;
    fsm_e               w_fsm_nxt;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_idx;
    logic               r_req;
    logic [NUM_CH-1:0]  r_pop;

    logic               w_idle;
    logic               w_srst;
    logic               w_any_data;
    logic [IDX_W-1:0]   w_rr_sel;
    logic               w_rr_valid;
    logic [IDX_W-1:0]   w_grant_ch;
    logic               w_grant_ok;
    logic               w_do_grant;

    assign w_idle     = (state == ST_IDLE);
    assign w_srst     = (state == ST_RESET);
    assign w_any_data = |(~empty);

    rr_next_sel #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_rr_next_sel (
        .i_ptr   (r_ptr),
        .i_empty (empty),
        .o_sel   (w_rr_sel),
        .o_valid (w_rr_valid)
    );

`ifdef VC_ARB_BURST_EN
    logic [3:0] r_burst;
    logic       w_keep;

    // Stay on the last channel while it still has data and its burst budget remains.
    assign w_keep     = (r_burst != 4'd0) && (r_burst < 4'(MAX_BURST)) && !empty[r_ptr];
    assign w_grant_ch = w_keep ? r_ptr : w_rr_sel;
    assign w_grant_ok = w_keep | w_rr_valid;

    // Burst length of consecutive grants to the same channel, saturating at 15.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_burst <= 4'd0;
        end else if (w_srst) begin
            r_burst <= 4'd0;
        end else if (w_do_grant) begin
            if ((w_grant_ch == r_ptr) && (r_burst != 4'd0)) begin
                r_burst <= (r_burst == 4'd15) ? 4'd15 : (r_burst + 4'd1);
            end else begin
                r_burst <= 4'd1;
            end
        end else begin
            r_burst <= r_burst;
        end
    end
`else
    assign w_grant_ch = w_rr_sel;
    assign w_grant_ok = w_rr_valid;
`endif

    // The grant commits in the GRANT cycle unless the link has left idle; pause is ignored here.
    assign w_do_grant = (r_fsm == FSM_GRANT) && w_idle && w_grant_ok;

    // FSM state register.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_fsm <= FSM_WAIT;
        end else if (w_srst) begin
            r_fsm <= FSM_WAIT;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    // Next-state logic; the GAP cycle lets empty flags settle after a pop.
    always_comb begin
        w_fsm_nxt = FSM_WAIT;
        case (r_fsm)
            FSM_WAIT:  w_fsm_nxt = (w_idle && !pause && w_any_data) ? FSM_GRANT : FSM_WAIT;
            FSM_GRANT: w_fsm_nxt = w_idle ? FSM_GAP : FSM_WAIT;
            FSM_GAP:   w_fsm_nxt = FSM_WAIT;
            default:   w_fsm_nxt = FSM_WAIT;
        endcase
    end

    // Round-robin pointer tracks the last granted channel.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_ptr <= IDX_W'(NUM_CH - 1);
        end else if (w_srst) begin
            r_ptr <= IDX_W'(NUM_CH - 1);
        end else if (w_do_grant) begin
            r_ptr <= w_grant_ch;
        end else begin
            r_ptr <= r_ptr;
        end
    end

    // Registered grant outputs: one-cycle req/pop strobe, idx held between grants.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_req <= 1'b0;
            r_pop <= '0;
            r_idx <= '0;
        end else if (w_do_grant) begin
            r_req <= 1'b1;
            r_pop <= NUM_CH'(1) << w_grant_ch;
            r_idx <= w_grant_ch;
        end else begin
            r_req <= 1'b0;
            r_pop <= '0;
            r_idx <= r_idx;
        end
    end

    assign idx = r_idx;
    assign req = r_req;
    assign pop = r_pop;

endmodule

// File: tb/tb_vc_arbiter.sv
// Directed self-checking bench for vc_arbiter (default parameters); expected
// grant sequences follow VC_ARB_BURST_EN when that macro is defined.
module tb_vc_arbiter;
    import vc_arb_pkg::*;

    logic       clk;
    logic       reset_L;
    logic [3:0] state;
    logic [4:0] empty;
    logic       pause;
    logic [2:0] idx;
    logic       req;
    logic [4:0] pop;

    int n_tests;
    int n_fail;

    vc_arbiter dut (
        .clk     (clk),
        .reset_L (reset_L),
        .state   (state),
        .empty   (empty),
        .pause   (pause),
        .idx     (idx),
        .req     (req),
        .pop     (pop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [4:0] e);
        reset_L = 1'b0;
        state   = ST_IDLE;
        empty   = e;
        pause   = 1'b0;
        repeat (2) step();
        reset_L = 1'b1;
    endtask

    task automatic test_reset();
        reset_L = 1'b0;
        state   = ST_IDLE;
        empty   = 5'b00000;
        pause   = 1'b0;
        repeat (3) step();
        n_tests++;
        if (req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %0b expected 0", req); end
        n_tests++;
        if (pop !== 5'b00000) begin n_fail++; $display("FAIL reset_pop: got %b expected 00000", pop); end
        n_tests++;
        if (idx !== 3'd0) begin n_fail++; $display("FAIL reset_idx: got %0d expected 0", idx); end
    endtask

    task automatic test_first_grant();
        do_reset(5'b11110);
        step();
        n_tests++;
        if (req !== 1'b0) begin n_fail++; $display("FAIL first_edge1_req: got %0b expected 0", req); end
        step();
        n_tests++;
        if (req !== 1'b1) begin n_fail++; $display("FAIL first_edge2_req: got %0b expected 1", req); end
        n_tests++;
        if (idx !== 3'd0) begin n_fail++; $display("FAIL first_idx: got %0d expected 0", idx); end
        n_tests++;
        if (pop !== 5'b00001) begin n_fail++; $display("FAIL first_pop: got %b expected 00001", pop); end
        empty = 5'b11111;
        for (int c = 0; c < 10; c++) begin
            step();
            n_tests++;
            if (req !== 1'b0 || pop !== 5'b00000) begin
                n_fail++;
                $display("FAIL drained_no_pop: cycle %0d req=%0b pop=%b expected 0/00000", c, req, pop);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_seq [9];
        logic [4:0] exp_pop;
        int n_exp;
        int n;
        int last_cyc;
`ifdef VC_ARB_BURST_EN
        exp_seq = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd1, 3'd2};
        n_exp   = 9;
`else
        exp_seq = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd0, 3'd0, 3'd0};
        n_exp   = 6;
`endif
        n = 0;
        last_cyc = 0;
        do_reset(5'b00000);
        for (int cyc = 1; cyc <= 60 && n < n_exp; cyc++) begin
            step();
            if (req === 1'b1) begin
                exp_pop = 5'b00001 << exp_seq[n];
                n_tests++;
                if (idx !== exp_seq[n]) begin
                    n_fail++;
                    $display("FAIL rr_idx[%0d]: got %0d expected %0d", n, idx, exp_seq[n]);
                end
                n_tests++;
                if (pop !== exp_pop) begin
                    n_fail++;
                    $display("FAIL rr_pop[%0d]: got %b expected %b", n, pop, exp_pop);
                end
                n_tests++;
                if (n == 0 && cyc != 2) begin
                    n_fail++;
                    $display("FAIL rr_first_cycle: got %0d expected 2", cyc);
                end else if (n != 0 && cyc - last_cyc != 3) begin
                    n_fail++;
                    $display("FAIL rr_spacing[%0d]: got %0d expected 3", n, cyc - last_cyc);
                end
                last_cyc = cyc;
                n++;
            end
        end
        n_tests++;
        if (n != n_exp) begin n_fail++; $display("FAIL rr_count: got %0d expected %0d", n, n_exp); end
    endtask

    task automatic test_pause();
        logic [2:0] exp_idx;
`ifdef VC_ARB_BURST_EN
        exp_idx = 3'd0;
`else
        exp_idx = 3'd1;
`endif
        do_reset(5'b00000);
        repeat (4) step();
        pause = 1'b1;
        step();
        n_tests++;
        if (req !== 1'b1 || idx !== exp_idx) begin
            n_fail++;
            $display("FAIL pause_grant_completes: req=%0b idx=%0d expected 1/%0d", req, idx, exp_idx);
        end
        for (int c = 0; c < 6; c++) begin
            step();
            n_tests++;
            if (req !== 1'b0) begin n_fail++; $display("FAIL pause_blocks: cycle %0d req=%0b expected 0", c, req); end
        end
        pause = 1'b0;
        step();
        n_tests++;
        if (req !== 1'b0) begin n_fail++; $display("FAIL unpause_c1: got %0b expected 0", req); end
        step();
        n_tests++;
        if (req !== 1'b1) begin n_fail++; $display("FAIL unpause_c2: got %0b expected 1", req); end
    endtask

    task automatic test_state_change();
        do_reset(5'b00000);
        repeat (2) step();
        state = ST_ACTIVE;
        for (int c = 0; c < 6; c++) begin
            step();
            n_tests++;
            if (req !== 1'b0 || pop !== 5'b00000) begin
                n_fail++;
                $display("FAIL active_no_req: cycle %0d req=%0b pop=%b expected 0/00000", c, req, pop);
            end
        end
        state = ST_RESET;
        repeat (2) step();
        state = ST_IDLE;
        step();
        step();
        n_tests++;
        if (req !== 1'b1 || idx !== 3'd0) begin
            n_fail++;
            $display("FAIL restart_first_idx: req=%0b idx=%0d expected 1/0", req, idx);
        end
        repeat (2) step();
        state = ST_INIT;
        step();
        n_tests++;
        if (req !== 1'b0 || pop !== 5'b00000) begin
            n_fail++;
            $display("FAIL leave_in_grant: req=%0b pop=%b expected 0/00000", req, pop);
        end
    endtask

    task automatic test_all_empty();
        do_reset(5'b11111);
        for (int c = 0; c < 12; c++) begin
            step();
            n_tests++;
            if (req !== 1'b0 || pop !== 5'b00000) begin
                n_fail++;
                $display("FAIL all_empty: cycle %0d req=%0b pop=%b expected 0/00000", c, req, pop);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset(5'b00000);
        repeat (2) step();
        n_tests++;
        if (req !== 1'b1) begin n_fail++; $display("FAIL async_pre_req: got %0b expected 1", req); end
        #2;
        reset_L = 1'b0;
        #1;
        n_tests++;
        if (req !== 1'b0 || pop !== 5'b00000) begin
            n_fail++;
            $display("FAIL async_reset_clear: req=%0b pop=%b expected 0/00000", req, pop);
        end
        step();
        reset_L = 1'b1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset_L = 1'b0;
        state   = ST_RESET;
        empty   = 5'b11111;
        pause   = 1'b0;
        test_reset();
        test_first_grant();
        test_round_robin();
        test_pause();
        test_state_change();
        test_all_empty();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
